// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM request-port arbiter.
//   arb_state_t : arbiter FSM states
//   mem_ctl_t   : control fields of a controller request (rw, access size, unsigned)
//   OPLEN_WORD  : access size code for a 32-bit word
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WDOG_W = 16;

  localparam logic [1:0] OPLEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_I  = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] oplen;
    logic       uns;
  } mem_ctl_t;

  // Instruction fetches are always unsigned-agnostic word loads.
  function automatic mem_ctl_t fetch_ctl();
    mem_ctl_t c;
    c.rw    = 1'b0;
    c.oplen = OPLEN_WORD;
    c.uns   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating busy-cycle counter with a sticky limit flag.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : clear the counter (transaction completed)
//   i_enable   : count this cycle (arbiter busy)
//   o_flag     : sticky, set when the counter reaches TIMEOUT; cleared only by reset
module mem_port_arbiter_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_flag
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] r_cnt;
  logic [WDOG_W-1:0] w_cnt_nxt;
  logic              r_flag;

  // Next count: clear wins, otherwise increment until the limit.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      w_cnt_nxt = r_cnt + WDOG_W'(1);
    end
  end

  // Flag rises on the same edge the counter lands on the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == LIMIT) begin
        r_flag <= 1'b1;
      end
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the SDRAM controller request port between the instruction-fetch
// and load/store requesters. A grant is registered and held for the whole
// transaction, followed by a one-cycle RELEASE gap.
//   clk, rst_n         : clock, async active-low reset
//   i_enable/i_addr    : fetch request;  i_valid/i_rdata : fetch completion
//   d_enable/d_rw/d_addr/d_wdata/d_oplen/d_unsigned : data request
//   d_valid/d_rdata    : data completion
//   m_*                : request to / completion from the controller
//   busy               : transaction outstanding
//   grant_d            : current/last grant went to the data port
//   err_timeout        : sticky, a transaction stayed busy for TIMEOUT cycles
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 25,
  parameter bit          DATA_PRIORITY = 1'b0,
  parameter int unsigned TIMEOUT       = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_enable,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_oplen,
  input  logic              d_unsigned,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_enable,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_oplen,
  output logic              m_unsigned,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              grant_d,
  output logic              err_timeout
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_grant;
  logic              w_sel_d;
  logic              w_done;
  logic              r_grant_d;
  logic              r_m_enable;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  mem_ctl_t          r_m_ctl;
  logic              w_busy;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant decision. r_grant_d doubles as last_grant:
  // on a tie without data priority, the port that did not win last time wins.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_sel_d     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (d_enable && (!i_enable || DATA_PRIORITY || !r_grant_d)) begin
          w_grant     = 1'b1;
          w_sel_d     = 1'b1;
          w_state_nxt = ARB_BUSY_D;
        end else if (i_enable) begin
          w_grant     = 1'b1;
          w_state_nxt = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (m_valid) begin
          w_done      = 1'b1;
          w_state_nxt = ARB_RELEASE;
        end
      end
      ARB_RELEASE: w_state_nxt = ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs decoded from state; completions pass m_valid/m_rdata straight through.
  always_comb begin
    w_busy  = (r_state == ARB_BUSY_I) || (r_state == ARB_BUSY_D);
    i_valid = (r_state == ARB_BUSY_I) && m_valid;
    d_valid = (r_state == ARB_BUSY_D) && m_valid;
    i_rdata = m_rdata;
    d_rdata = m_rdata;
  end

  // Request registers: captured only at grant, held until completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_enable <= 1'b0;
      r_grant_d  <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_ctl    <= '0;
    end else if (w_grant) begin
      r_m_enable <= 1'b1;
      r_grant_d  <= w_sel_d;
      if (w_sel_d) begin
        r_m_addr      <= d_addr;
        r_m_wdata     <= d_wdata;
        r_m_ctl.rw    <= d_rw;
        r_m_ctl.oplen <= d_oplen;
        r_m_ctl.uns   <= d_unsigned;
      end else begin
        r_m_addr  <= i_addr;
        r_m_wdata <= '0;
        r_m_ctl   <= fetch_ctl();
      end
    end else if (w_done) begin
      r_m_enable <= 1'b0;
    end
  end

  mem_port_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_done),
    .i_enable (w_busy),
    .o_flag   (err_timeout)
  );

  assign busy       = w_busy;
  assign grant_d    = r_grant_d;
  assign m_enable   = r_m_enable;
  assign m_rw       = r_m_ctl.rw;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign m_oplen    = r_m_ctl.oplen;
  assign m_unsigned = r_m_ctl.uns;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance 0: round-robin, TIMEOUT=8.
// Instance 1: data priority. Requester inputs and rst_n are shared; each
// instance has its own m_valid so only the instance under test completes.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 25;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_enable, d_enable, d_rw, d_unsigned;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata, m_rdata;
  logic [1:0]    d_oplen;
  logic [1:0]    mv;

  logic [1:0]    iv, dv, me, mrw, mun, bsy, gd, et;
  logic [31:0]   ir [2];
  logic [31:0]   dr [2];
  logic [31:0]   mw [2];
  logic [AW-1:0] ma [2];
  logic [1:0]    mo [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_PRIORITY(1'b0), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_enable(i_enable), .i_addr(i_addr), .i_valid(iv[0]), .i_rdata(ir[0]),
    .d_enable(d_enable), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_oplen(d_oplen), .d_unsigned(d_unsigned), .d_valid(dv[0]), .d_rdata(dr[0]),
    .m_enable(me[0]), .m_rw(mrw[0]), .m_addr(ma[0]), .m_wdata(mw[0]),
    .m_oplen(mo[0]), .m_unsigned(mun[0]), .m_valid(mv[0]), .m_rdata(m_rdata),
    .busy(bsy[0]), .grant_d(gd[0]), .err_timeout(et[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_PRIORITY(1'b1), .TIMEOUT(1023)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_enable(i_enable), .i_addr(i_addr), .i_valid(iv[1]), .i_rdata(ir[1]),
    .d_enable(d_enable), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_oplen(d_oplen), .d_unsigned(d_unsigned), .d_valid(dv[1]), .d_rdata(dr[1]),
    .m_enable(me[1]), .m_rw(mrw[1]), .m_addr(ma[1]), .m_wdata(mw[1]),
    .m_oplen(mo[1]), .m_unsigned(mun[1]), .m_valid(mv[1]), .m_rdata(m_rdata),
    .busy(bsy[1]), .grant_d(gd[1]), .err_timeout(et[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_enable = 1'b0; i_addr = '0;
    d_enable = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
    d_oplen = 2'b00; d_unsigned = 1'b0;
    m_rdata = '0; mv = 2'b00;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Entered in the cycle after the grant edge; leaves in the RELEASE cycle.
  task automatic serve(input int k, input int lat, input logic exp_gd,
                       input logic [AW-1:0] exp_addr, input logic [31:0] rd);
    chk("grant_m_enable", 64'(me[k]), 64'd1);
    chk("grant_d", 64'(gd[k]), 64'(exp_gd));
    chk("grant_m_addr", 64'(ma[k]), 64'(exp_addr));
    chk("grant_busy", 64'(bsy[k]), 64'd1);
    repeat (lat - 1) tick();
    chk("hold_m_enable", 64'(me[k]), 64'd1);
    chk("hold_m_addr", 64'(ma[k]), 64'(exp_addr));
    tick();
    mv[k] = 1'b1;
    m_rdata = rd;
    #1;
    if (exp_gd) begin
      chk("d_valid", 64'(dv[k]), 64'd1);
      chk("d_rdata", 64'(dr[k]), 64'(rd));
      chk("i_valid_quiet", 64'(iv[k]), 64'd0);
    end else begin
      chk("i_valid", 64'(iv[k]), 64'd1);
      chk("i_rdata", 64'(ir[k]), 64'(rd));
      chk("d_valid_quiet", 64'(dv[k]), 64'd0);
    end
    tick();
    mv[k] = 1'b0;
    #1;
    chk("rel_m_enable", 64'(me[k]), 64'd0);
    chk("rel_busy", 64'(bsy[k]), 64'd0);
    chk("rel_valid", 64'({iv[k], dv[k]}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    clear_inputs();
    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_m_enable", 64'(me[0]), 64'd0);
    chk("rst_m_addr", 64'(ma[0]), 64'd0);
    chk("rst_m_wdata", 64'(mw[0]), 64'd0);
    chk("rst_m_ctl", 64'({mrw[0], mo[0], mun[0]}), 64'd0);
    chk("rst_flags", 64'({gd[0], et[0], bsy[0], iv[0], dv[0]}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch only
    i_enable = 1'b1;
    i_addr = 25'h40;
    #1;
    chk("fetch_latency", 64'(me[0]), 64'd0);
    tick();
    chk("fetch_ctl", 64'({mrw[0], mo[0], mun[0]}), 64'({1'b0, 2'b10, 1'b0}));
    serve(0, 3, 1'b0, 25'h40, 32'h0010_0093);
    tick();
    i_enable = 1'b0;
    #1;
    chk("release_absorbs_enable", 64'(me[0]), 64'd0);
    mv[0] = 1'b1;
    #1;
    chk("stray_m_valid", 64'({iv[0], dv[0]}), 64'd0);
    tick();
    mv[0] = 1'b0;
    chk("idle_stays", 64'({me[0], bsy[0]}), 64'd0);

    // Store
    d_enable = 1'b1; d_rw = 1'b1; d_addr = 25'h1F00;
    d_wdata = 32'hDEAD_BEEF; d_oplen = 2'b01; d_unsigned = 1'b0;
    tick();
    chk("store_wdata", 64'(mw[0]), 64'hDEAD_BEEF);
    chk("store_ctl", 64'({mrw[0], mo[0], mun[0]}), 64'({1'b1, 2'b01, 1'b0}));
    serve(0, 2, 1'b1, 25'h1F00, 32'hCAFE_0001);
    tick();
    d_enable = 1'b0;
    tick();
    chk("store_idle", 64'(me[0]), 64'd0);

    // Simultaneous, round-robin from reset
    do_reset();
    i_enable = 1'b1; i_addr = 25'h100;
    d_enable = 1'b1; d_addr = 25'h200; d_rw = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      serve(0, 2, ((t % 2) == 0), ((t % 2) == 0) ? 25'h200 : 25'h100, 32'h1000 + 32'(t));
      tick();
      chk("rr_idle_gap", 64'(me[0]), 64'd0);
    end
    i_enable = 1'b0; d_enable = 1'b0;

    // Data priority instance: data always wins
    do_reset();
    i_enable = 1'b1; i_addr = 25'h100;
    d_enable = 1'b1; d_addr = 25'h200;
    for (int t = 0; t < 3; t++) begin
      tick();
      serve(1, 2, 1'b1, 25'h200, 32'h2000 + 32'(t));
      tick();
      chk("prio_idle_gap", 64'(me[1]), 64'd0);
    end
    i_enable = 1'b0; d_enable = 1'b0;

    // Data requester drops enable right after grant
    do_reset();
    d_enable = 1'b1; d_addr = 25'h300; d_rw = 1'b0; d_oplen = 2'b00;
    tick();
    d_enable = 1'b0;
    serve(0, 3, 1'b1, 25'h300, 32'h0000_00A5);
    tick();
    tick();
    chk("drop_no_regrant", 64'({me[0], bsy[0]}), 64'd0);

    // Watchdog with TIMEOUT=8, completion after 20 cycles
    do_reset();
    i_enable = 1'b1; i_addr = 25'h44;
    tick();
    chk("wd_clear_at_grant", 64'(et[0]), 64'd0);
    repeat (7) tick();
    chk("wd_before_limit", 64'(et[0]), 64'd0);
    tick();
    chk("wd_at_limit", 64'(et[0]), 64'd1);
    repeat (11) tick();
    chk("wd_still_busy", 64'({me[0], bsy[0]}), 64'b11);
    tick();
    mv[0] = 1'b1; m_rdata = 32'h0BAD_F00D;
    #1;
    chk("wd_late_valid", 64'(iv[0]), 64'd1);
    chk("wd_late_rdata", 64'(ir[0]), 64'h0BAD_F00D);
    tick();
    mv[0] = 1'b0;
    i_enable = 1'b0;
    #1;
    chk("wd_sticky", 64'({et[0], me[0]}), 64'b10);
    tick();
    tick();

    // Reset mid-transaction
    i_enable = 1'b1; i_addr = 25'h88;
    tick();
    chk("mid_grant", 64'(me[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m", 64'({me[0], mrw[0], mo[0], mun[0]}), 64'd0);
    chk("mid_rst_addr", 64'(ma[0]), 64'd0);
    chk("mid_rst_flags", 64'({gd[0], et[0], bsy[0], iv[0], dv[0]}), 64'd0);
    tick();
    rst_n = 1'b1;
    i_enable = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
